// File: rtl/uart_tx_fifo_if.sv
// Write-side bus and status bundle of the buffered UART transmitter.
// The master modport is the CPU/bus side; the slave modport is the transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                full;
  logic [DEPTH_LOG2:0] level;
  logic                busy;
  logic                txd;

  modport master (
    output wr_en, wr_data,
    input  full, level, busy, txd
  );

  modport slave (
    input  wr_en, wr_data,
    output full, level, busy, txd
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: power-of-two byte FIFO feeding an 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7 (11-bit frames).
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned CW    = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_level;
  logic            r_full;
  logic            r_busy;
  logic            r_txd;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_par;

  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_last;
  logic            w_frame_end;
  logic [7:0]      w_rd_data;
  logic [PW-1:0]   w_wptr_nxt;
  logic [PW-1:0]   w_rptr_nxt;
  logic            w_busy_nxt;

  // Pointer bookkeeping; full is the registered flag, so a same-cycle pop never frees a slot
  assign w_empty     = (r_wptr == r_rptr);
  assign w_push      = bus.wr_en && !r_full;
  assign w_last      = (r_baud == CW'(DIV - 1));
  assign w_frame_end = (r_state == S_STOP) && w_last;
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);
  assign w_rd_data   = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign w_wptr_nxt  = w_push ? r_wptr + PW'(1) : r_wptr;
  assign w_rptr_nxt  = w_pop  ? r_rptr + PW'(1) : r_rptr;

  // Still busy next cycle if anything stays queued, a frame starts, or the current frame continues
  assign w_busy_nxt  = (w_wptr_nxt != w_rptr_nxt) || w_pop ||
                       ((r_state != S_IDLE) && !w_frame_end);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[DEPTH_LOG2-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_level <= w_wptr_nxt - w_rptr_nxt;
      r_full  <= (w_wptr_nxt[PW-1] != w_rptr_nxt[PW-1]) &&
                 (w_wptr_nxt[PW-2:0] == w_rptr_nxt[PW-2:0]);
      r_busy  <= w_busy_nxt;
      r_baud  <= ((r_state == S_IDLE) || w_last) ? '0 : r_baud + CW'(1);

      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= w_rd_data;
            r_par   <= ^w_rd_data;
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_last) begin
            r_bit   <= '0;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_last) begin
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= r_par;
              r_state <= S_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_last) begin
            r_txd   <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Back-to-back frames: reload straight into START with no idle bit time
          if (w_last) begin
            if (w_pop) begin
              r_shift <= w_rd_data;
              r_par   <= ^w_rd_data;
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.full  = r_full;
  assign bus.level = r_level;
  assign bus.busy  = r_busy;
  assign bus.txd   = r_txd;

endmodule
